i2s_tx: RTL and testbench

Serial audio transmitter at the output end of the synth datapath. Accepts 18-bit offset-binary mixed samples (mid-scale 0x20000 = silence) through a valid/ready handshake, converts them to two's complement and shifts them out as standard Philips I2S, with the mono sample duplicated on the left and right slots. Drives an external DAC. Generates BCLK and LRCLK itself as master, from the system clock.

---
 rtl/synth_audio_pkg.sv | 19 +
 rtl/i2s_bclk_gen.sv | 32 +++
 rtl/i2s_tx.sv | 87 ++++++++
 tb/tb_i2s_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/synth_audio_pkg.sv
// rtl/synth_audio_pkg.sv - shared audio sample widths, I2S frame constants and format helpers
package synth_audio_pkg;

    localparam int SAMPLE_W   = 18;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int POS_W      = $clog2(FRAME_BITS);
    localparam int BIT_W      = $clog2(SLOT_W);

    typedef logic [SAMPLE_W-1:0] sample_t;

    localparam sample_t MIDSCALE = 18'h20000;

    // Offset-binary to two's complement is an MSB flip around mid-scale.
    function automatic sample_t ob_to_tc(input sample_t ob);
        return ob ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - bit clock divider with a strobe on the cycle bclk falls
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk,
    output logic fall
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap = (div_cnt == CNT_MAX);
    assign fall = wrap && bclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S master transmitter, mono sample duplicated on left and right slots
module i2s_tx
    import synth_audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                underrun
);

    logic             fall;
    sample_t          hold;
    sample_t          frame;
    sample_t          frame_nxt;
    logic             full;
    logic [POS_W-1:0] p;
    logic [POS_W-1:0] p_nxt;
    logic [BIT_W-1:0] k;
    logic             accept;
    logic             load;
    logic             lrclk_nxt;
    logic             sdata_nxt;

    i2s_bclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_bclk_gen (
        .clk (clk),
        .rst (rst),
        .bclk(bclk),
        .fall(fall)
    );

    assign s_ready = !full;
    assign accept  = s_valid && !full;
    assign p_nxt   = p + POS_W'(1);
    assign load    = fall && (p == POS_W'(FRAME_BITS - 1));

    // Output mux looks at the slot position and frame as they will be after this edge.
    always_comb begin
        frame_nxt = frame;
        if (load && full) begin
            frame_nxt = hold;
        end
        k         = p_nxt[BIT_W-1:0];
        lrclk_nxt = (p_nxt >= POS_W'(SLOT_W - 1)) && (p_nxt <= POS_W'(FRAME_BITS - 2));
        sdata_nxt = 1'b0;
        if (k < BIT_W'(SAMPLE_W)) begin
            sdata_nxt = frame_nxt[BIT_W'(SAMPLE_W - 1) - k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold     <= '0;
            full     <= 1'b0;
            frame    <= '0;
            p        <= '1;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= load && !full;
            frame    <= frame_nxt;
            if (load && full) begin
                full <= 1'b0;
            end
            // A sample accepted on an empty-load edge is kept for the next frame.
            if (accept) begin
                hold <= ob_to_tc(s_data);
                full <= 1'b1;
            end
            if (fall) begin
                p     <= p_nxt;
                lrclk <= lrclk_nxt;
                sdata <= sdata_nxt;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - scoreboard bench decoding the I2S stream against queued frame values
module tb_i2s_tx;

    localparam int CLK_DIV    = 4;
    localparam int FRAME_CLKS = 128 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .bclk    (bclk),
        .lrclk   (lrclk),
        .sdata   (sdata),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] val;
        bit          und;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   falls = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    function automatic void push(input logic [17:0] val, input bit und);
        exp_t e;
        e.val = val;
        e.und = und;
        exp_q.push_back(e);
    endfunction

    // Monitor: behaves like the DAC, sampling on bclk rising and framing words on lrclk changes.
    initial begin : monitor
        logic [31:0] word;
        int          cnt;
        int          und_cnt;
        int          gap;
        bit          gap_ok;
        logic        lr_last;
        logic        bclk_q;
        logic        lr_q;
        logic        sd_q;
        word = '0; cnt = -1; und_cnt = 0; gap = 0; gap_ok = 0;
        lr_last = 1'b0; bclk_q = 1'b0; lr_q = 1'b0; sd_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                word = '0; cnt = -1; und_cnt = 0; gap = 0; gap_ok = 0; falls = 0;
                lr_last = 1'b0; bclk_q = bclk; lr_q = lrclk; sd_q = sdata;
            end else begin
                gap++;
                if (bclk_q && !bclk) falls++;
                if (underrun) und_cnt++;
                if (lrclk !== lr_q || sdata !== sd_q)
                    check("out_change_on_fall", 32'(bclk_q && !bclk), 32'd1);
                if (bclk !== bclk_q) begin
                    if (gap_ok) check("bclk_half_period", 32'(gap), 32'(CLK_DIV));
                    gap_ok = 1;
                    gap = 0;
                    if (bclk) begin
                        word = {word[30:0], sdata};
                        cnt++;
                        if (lrclk !== lr_last) begin
                            check("word_len", 32'(cnt), 32'd32);
                            if (exp_q.size() == 0) begin
                                n_vec++;
                                n_bad++;
                                $display("FAIL queue_empty: got word %h expected no word", word);
                            end else if (!lr_last) begin
                                check("left_word", word, {exp_q[0].val, 14'b0});
                                check("underrun_count", 32'(und_cnt), 32'(exp_q[0].und));
                            end else begin
                                check("right_word", word, {exp_q[0].val, 14'b0});
                                void'(exp_q.pop_front());
                                und_cnt = 0;
                            end
                            lr_last = lrclk;
                            cnt = 0;
                        end
                    end
                end
                bclk_q = bclk;
                lr_q = lrclk;
                sd_q = sdata;
            end
        end
    end

    task automatic wait_falls(input int target);
        int t;
        t = 0;
        while (falls < target) begin
            @(posedge clk);
            t++;
            if (t > 12 * FRAME_CLKS) begin
                n_vec++;
                n_bad++;
                $display("FAIL wait_falls: got %0d falls expected %0d", falls, target);
                finish_run();
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [17:0] v, input bit keep_valid, input int exp_falls);
        bit rdy;
        int t;
        t = 0;
        s_data = v;
        s_valid = 1'b1;
        do begin
            rdy = s_ready;
            @(posedge clk); #1;
            t++;
            if (t > 2 * FRAME_CLKS) begin
                n_vec++;
                n_bad++;
                $display("FAIL send_timeout: got no accept expected accept of %h", v);
                finish_run();
            end
        end while (!rdy);
        check("s_ready_drop", 32'(s_ready), 32'd0);
        check("accept_frame", 32'(falls), 32'(exp_falls));
        if (!keep_valid) s_valid = 1'b0;
    endtask

    initial begin : watchdog
        #(FRAME_CLKS * 40 * 10);
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got no end expected end of run");
        finish_run();
    end

    initial begin : stimulus
        apply_reset();
        push(18'h00000, 1'b1);
        push(18'h00000, 1'b1);
        push(18'h00000, 1'b1);
        wait_falls(193);
        check("queue_drained_idle", 32'(exp_q.size()), 32'd0);

        apply_reset();
        push(18'h1FFFF, 1'b0);
        push(18'h20000, 1'b0);
        push(18'h00001, 1'b0);
        push(18'h32345, 1'b0);
        push(18'h0ABCD, 1'b0);
        push(18'h0ABCD, 1'b1);
        push(18'h0ABCD, 1'b1);
        push(18'h3F00F, 1'b0);
        push(18'h2F0F0, 1'b0);
        send(18'h3FFFF, 1'b1, 0);
        send(18'h00000, 1'b1, 1);
        send(18'h20001, 1'b1, 65);
        send(18'h12345, 1'b1, 129);
        send(18'h2ABCD, 1'b0, 193);

        // Present a sample exactly on the edge of the frame-7 load with the holding register empty.
        wait_falls(384);
        repeat (2 * CLK_DIV - 2) @(posedge clk);
        #1;
        check("empty_before_load", 32'(s_ready), 32'd1);
        s_data = 18'h1F00F;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("load_edge_underrun", 32'(underrun), 32'd1);
        check("load_edge_accept", 32'(s_ready), 32'd0);

        wait_falls(449);
        send(18'h0F0F0, 1'b0, 449);
        wait_falls(553);
        apply_reset();
        push(18'h00000, 1'b1);
        push(18'h00000, 1'b1);
        wait_falls(129);
        check("queue_drained_end", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

endmodule
